fetch_unit: RTL and testbench

Instruction fetch stage for the MIPS datapath. Holds the PC, runs a req/ack fetch handshake against instruction memory, and drives the IF/ID pipeline register. The IF/ID register supports stall and redirect (flush). Its `imm16` output feeds the sign extender directly; `instr` feeds the decoder and register-file address fields.

---
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//   Instruction-memory fetch handshake between the fetch stage and memory.
//
//   Signals
//     req    fetch request (driven by fetch side)
//     addr   word-aligned fetch address, stable while req=1 and no ack
//     ack    memory returns rdata this cycle (may coincide with req)
//     rdata  fetched instruction word
//
//   Modports
//     master  fetch side (drives req/addr, samples ack/rdata)
//     slave   memory side (samples req/addr, drives ack/rdata)
// ---------------------------------------------------------------------------
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage for the MIPS datapath. Holds the PC, runs a
//   req/ack handshake against instruction memory, and drives the IF/ID
//   pipeline register with stall and redirect (flush) support. A one-entry
//   skid buffer catches a word that arrives while the pipeline is stalled.
//
//   Parameters
//     RESET_PC        PC value loaded on reset
//
//   Ports
//     clk             system clock, rising edge
//     rst_n           synchronous, active-low reset
//     imem            instruction-memory handshake (master side)
//     i_stall         hazard unit: hold the IF/ID register
//     i_redirect      branch/jump taken: flush and refetch
//     i_redirect_pc   redirect target (bits [1:0] forced to 0)
//     o_instr         IF/ID instruction word
//     o_instr_valid   IF/ID holds a real instruction
//     o_pc_out        PC of o_instr
//     o_pc_plus4      o_pc_out + 4
//     o_imm16         o_instr[15:0], to the sign extender
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master imem,
  input  logic         i_stall,
  input  logic         i_redirect,
  input  logic [31:0]  i_redirect_pc,
  output logic [31:0]  o_instr,
  output logic         o_instr_valid,
  output logic [31:0]  o_pc_out,
  output logic [31:0]  o_pc_plus4,
  output logic [15:0]  o_imm16
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;
  logic [31:0] r_pc_out;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic        r_pend;
  logic [31:0] r_pend_pc;

  logic [31:0] w_redirect_tgt;
  logic        w_unused_bits;

  // Targets are always word aligned; the low bits of the request are dropped.
  assign w_redirect_tgt = {i_redirect_pc[31:2], 2'b00};
  assign w_unused_bits  = &{1'b0, i_redirect_pc[1:0]};

  // The request is gated by rst_n so memory never sees a request while reset
  // is held, yet it rises in the very first cycle after reset releases.
  assign imem.req  = (r_state == S_FETCH) & rst_n;
  assign imem.addr = r_pc;

  assign o_instr       = r_instr;
  assign o_instr_valid = r_valid;
  assign o_pc_out      = r_pc_out;
  assign o_pc_plus4    = r_pc_out + 32'd4;
  assign o_imm16       = r_instr[15:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_instr      <= 32'h0000_0000;
      r_valid      <= 1'b0;
      r_pc_out     <= RESET_PC;
      r_skid_instr <= 32'h0000_0000;
      r_skid_pc    <= 32'h0000_0000;
      r_pend       <= 1'b0;
      r_pend_pc    <= 32'h0000_0000;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (i_redirect) begin
            // Flush wins over stall.
            r_valid <= 1'b0;
            r_instr <= 32'h0000_0000;
            if (imem.ack) begin
              // Request completes now: drop its data, jump straight away.
              r_pc   <= w_redirect_tgt;
              r_pend <= 1'b0;
            end else begin
              // Address must stay stable until the outstanding ack, so the
              // target is parked; a later redirect simply overwrites it.
              r_pend    <= 1'b1;
              r_pend_pc <= w_redirect_tgt;
            end
          end else if (imem.ack) begin
            if (r_pend) begin
              // Late word of a redirected-away fetch: discard and retarget.
              r_pc   <= r_pend_pc;
              r_pend <= 1'b0;
              if (!i_stall) begin
                r_valid <= 1'b0;
              end
            end else if (i_stall) begin
              // IF/ID is busy; park the word until the stall clears.
              r_skid_instr <= imem.rdata;
              r_skid_pc    <= r_pc;
              r_state      <= S_HOLD;
            end else begin
              r_instr  <= imem.rdata;
              r_pc_out <= r_pc;
              r_valid  <= 1'b1;
              r_pc     <= r_pc + 32'd4;
            end
          end else if (!i_stall) begin
            // Nothing arrived and the stage is free to advance: bubble.
            r_valid <= 1'b0;
          end
        end

        S_HOLD: begin
          if (i_redirect) begin
            r_valid <= 1'b0;
            r_instr <= 32'h0000_0000;
            r_pc    <= w_redirect_tgt;
            r_pend  <= 1'b0;
            r_state <= S_FETCH;
          end else if (!i_stall) begin
            r_instr  <= r_skid_instr;
            r_pc_out <= r_skid_pc;
            r_valid  <= 1'b1;
            r_pc     <= r_skid_pc + 32'd4;
            r_state  <= S_FETCH;
          end
        end

        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [15:0] imm16;

  int total;
  int bad;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (32'h0000_3000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (bus),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_instr       (instr),
    .o_instr_valid (instr_valid),
    .o_pc_out      (pc_out),
    .o_pc_plus4    (pc_plus4),
    .o_imm16       (imm16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and land 1 time unit past the edge for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    bus.ack     = 1'b0;
    bus.rdata   = 32'h0;
    step();
    step();
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", bus.req); end
    total++; if (bus.addr !== 32'h0000_3000) begin bad++; $display("FAIL rst_addr got=%h exp=00003000", bus.addr); end
    total++; if ({instr_valid, instr} !== {1'b0, 32'h0}) begin bad++; $display("FAIL rst_ifid got=%b/%h exp=0/00000000", instr_valid, instr); end
    total++; if ({pc_out, pc_plus4, imm16} !== {32'h0000_3000, 32'h0000_3004, 16'h0}) begin bad++; $display("FAIL rst_pc got=%h/%h/%h exp=00003000/00003004/0000", pc_out, pc_plus4, imm16); end
    rst_n = 1'b1;
    #1;
    total++; if ({bus.req, bus.addr} !== {1'b1, 32'h0000_3000}) begin bad++; $display("FAIL first_req got=%b/%h exp=1/00003000", bus.req, bus.addr); end
    $display("reset: req=%b addr=%h", bus.req, bus.addr);
  endtask

  task automatic test_zero_wait();
    bus.ack   = 1'b1;
    bus.rdata = 32'h2008_0005;
    step();
    total++; if ({instr_valid, instr} !== {1'b1, 32'h2008_0005}) begin bad++; $display("FAIL zw_instr0 got=%b/%h exp=1/20080005", instr_valid, instr); end
    total++; if ({imm16, pc_out, pc_plus4, bus.addr} !== {16'h0005, 32'h3000, 32'h3004, 32'h3004}) begin bad++; $display("FAIL zw_pc0 got=%h/%h/%h/%h exp=0005/3000/3004/3004", imm16, pc_out, pc_plus4, bus.addr); end
    $display("zero-wait: instr=%h pc=%h", instr, pc_out);
    bus.rdata = 32'h2009_FFFF;
    step();
    total++; if ({imm16, pc_out, pc_plus4, bus.addr} !== {16'hFFFF, 32'h3004, 32'h3008, 32'h3008}) begin bad++; $display("FAIL zw_pc1 got=%h/%h/%h/%h exp=ffff/3004/3008/3008", imm16, pc_out, pc_plus4, bus.addr); end
    $display("zero-wait: instr=%h pc=%h", instr, pc_out);
    bus.rdata = 32'h2010_0001;
    step();
    total++; if ({instr_valid, instr, pc_out, bus.addr} !== {1'b1, 32'h2010_0001, 32'h3008, 32'h300C}) begin bad++; $display("FAIL zw_pc2 got=%b/%h/%h/%h exp=1/20100001/3008/300c", instr_valid, instr, pc_out, bus.addr); end
    $display("zero-wait: instr=%h pc=%h", instr, pc_out);
    bus.ack = 1'b0;
    step();
    total++; if ({instr_valid, bus.addr} !== {1'b0, 32'h300C}) begin bad++; $display("FAIL zw_bubble got=%b/%h exp=0/300c", instr_valid, bus.addr); end
    $display("bubble: valid=%b addr=%h", instr_valid, bus.addr);
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 2; i++) begin
      logic [31:0] a;
      logic [31:0] w;
      a = 32'h300C + 32'(i) * 32'd4;
      w = 32'h8C01_0010 + 32'(i) * 32'd4;
      bus.ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
        step();
        total++; if ({bus.req, bus.addr, instr_valid} !== {1'b1, a, 1'b0}) begin bad++; $display("FAIL ws_wait%0d_%0d got=%b/%h/%b exp=1/%h/0", i, k, bus.req, bus.addr, instr_valid, a); end
      end
      bus.ack   = 1'b1;
      bus.rdata = w;
      step();
      bus.ack = 1'b0;
      total++; if ({instr_valid, instr, pc_out, bus.addr} !== {1'b1, w, a, a + 32'd4}) begin bad++; $display("FAIL ws_issue%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", i, instr_valid, instr, pc_out, bus.addr, w, a, a + 32'd4); end
      $display("wait-state fetch: instr=%h pc=%h", instr, pc_out);
    end
  endtask

  task automatic test_stall();
    stall     = 1'b1;
    bus.ack   = 1'b1;
    bus.rdata = 32'h0001_2020;
    step();
    bus.rdata = 32'hBAD0_0000;
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL st_req got=%b exp=0", bus.req); end
    total++; if ({instr_valid, instr, pc_out} !== {1'b1, 32'h8C01_0014, 32'h3010}) begin bad++; $display("FAIL st_hold0 got=%b/%h/%h exp=1/8c010014/3010", instr_valid, instr, pc_out); end
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if ({bus.req, instr_valid, instr, pc_out} !== {1'b0, 1'b1, 32'h8C01_0014, 32'h3010}) begin bad++; $display("FAIL st_hold%0d got=%b/%b/%h/%h exp=0/1/8c010014/3010", k + 1, bus.req, instr_valid, instr, pc_out); end
    end
    stall     = 1'b0;
    bus.rdata = 32'h0002_2020;
    step();
    total++; if ({bus.req, instr_valid, instr, pc_out, bus.addr} !== {1'b1, 1'b1, 32'h0001_2020, 32'h3014, 32'h3018}) begin bad++; $display("FAIL st_release got=%b/%b/%h/%h/%h exp=1/1/00012020/3014/3018", bus.req, instr_valid, instr, pc_out, bus.addr); end
    $display("stall release: instr=%h pc=%h", instr, pc_out);
    step();
    bus.ack = 1'b0;
    total++; if ({instr_valid, instr, pc_out, bus.addr} !== {1'b1, 32'h0002_2020, 32'h3018, 32'h301C}) begin bad++; $display("FAIL st_next got=%b/%h/%h/%h exp=1/00022020/3018/301c", instr_valid, instr, pc_out, bus.addr); end
    $display("after stall: instr=%h pc=%h", instr, pc_out);
  endtask

  task automatic test_redirect_pending();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3043;
    step();
    redirect = 1'b0;
    total++; if ({instr_valid, instr, bus.addr} !== {1'b0, 32'h0, 32'h301C}) begin bad++; $display("FAIL rp_flush got=%b/%h/%h exp=0/00000000/301c", instr_valid, instr, bus.addr); end
    step();
    total++; if ({instr_valid, bus.addr} !== {1'b0, 32'h301C}) begin bad++; $display("FAIL rp_stable got=%b/%h exp=0/301c", instr_valid, bus.addr); end
    bus.ack   = 1'b1;
    bus.rdata = 32'hDEAD_BEEF;
    step();
    total++; if ({instr_valid, bus.addr} !== {1'b0, 32'h3040}) begin bad++; $display("FAIL rp_drop got=%b/%h exp=0/3040", instr_valid, bus.addr); end
    bus.rdata = 32'h1000_0003;
    step();
    total++; if ({instr_valid, instr, pc_out, bus.addr} !== {1'b1, 32'h1000_0003, 32'h3040, 32'h3044}) begin bad++; $display("FAIL rp_target got=%b/%h/%h/%h exp=1/10000003/3040/3044", instr_valid, instr, pc_out, bus.addr); end
    $display("redirect pending: instr=%h pc=%h", instr, pc_out);
    // Two redirects while waiting: the second target wins.
    bus.ack     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_5000;
    step();
    redirect_pc = 32'h0000_6006;
    step();
    redirect  = 1'b0;
    bus.ack   = 1'b1;
    bus.rdata = 32'hDEAD_BEEF;
    step();
    total++; if ({instr_valid, bus.addr} !== {1'b0, 32'h6004}) begin bad++; $display("FAIL rp_overwrite got=%b/%h exp=0/6004", instr_valid, bus.addr); end
    bus.rdata = 32'h2406_0006;
    step();
    total++; if ({instr_valid, instr, pc_out} !== {1'b1, 32'h2406_0006, 32'h6004}) begin bad++; $display("FAIL rp_overwrite_tgt got=%b/%h/%h exp=1/24060006/6004", instr_valid, instr, pc_out); end
    $display("redirect overwrite: instr=%h pc=%h", instr, pc_out);
  endtask

  task automatic test_redirect_hold();
    stall     = 1'b1;
    bus.ack   = 1'b1;
    bus.rdata = 32'h2407_0007;
    step();
    total++; if ({bus.req, bus.addr} !== {1'b0, 32'h6008}) begin bad++; $display("FAIL rh_hold got=%b/%h exp=0/6008", bus.req, bus.addr); end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_7000;
    step();
    redirect = 1'b0;
    total++; if ({bus.req, instr_valid, instr, bus.addr} !== {1'b1, 1'b0, 32'h0, 32'h7000}) begin bad++; $display("FAIL rh_flush got=%b/%b/%h/%h exp=1/0/00000000/7000", bus.req, instr_valid, instr, bus.addr); end
    stall     = 1'b0;
    bus.rdata = 32'h2408_0008;
    step();
    total++; if ({instr_valid, instr, pc_out} !== {1'b1, 32'h2408_0008, 32'h7000}) begin bad++; $display("FAIL rh_target got=%b/%h/%h exp=1/24080008/7000", instr_valid, instr, pc_out); end
    $display("redirect in hold: instr=%h pc=%h", instr, pc_out);
  endtask

  task automatic test_redirect_zero_wait();
    bus.ack     = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_8001;
    bus.rdata   = 32'hDEAD_BEEF;
    step();
    redirect = 1'b0;
    total++; if ({instr_valid, bus.addr} !== {1'b0, 32'h8000}) begin bad++; $display("FAIL rz_penalty got=%b/%h exp=0/8000", instr_valid, bus.addr); end
    bus.rdata = 32'h2409_0009;
    step();
    total++; if ({instr_valid, instr, pc_out} !== {1'b1, 32'h2409_0009, 32'h8000}) begin bad++; $display("FAIL rz_target got=%b/%h/%h exp=1/24090009/8000", instr_valid, instr, pc_out); end
    $display("redirect same-cycle ack: instr=%h pc=%h", instr, pc_out);
  endtask

  task automatic test_wrap();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    total++; if (bus.addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wr_addr got=%h exp=fffffffc", bus.addr); end
    bus.rdata = 32'h240A_000A;
    step();
    total++; if ({instr_valid, pc_out, pc_plus4, bus.addr} !== {1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0}) begin bad++; $display("FAIL wr_wrap got=%b/%h/%h/%h exp=1/fffffffc/00000000/00000000", instr_valid, pc_out, pc_plus4, bus.addr); end
    $display("wrap: pc=%h next addr=%h", pc_out, bus.addr);
  endtask

  task automatic test_reset_mid_wait();
    bus.ack = 1'b0;
    stall   = 1'b1;
    step();
    total++; if ({instr_valid, instr, bus.addr} !== {1'b1, 32'h240A_000A, 32'h0}) begin bad++; $display("FAIL rm_held got=%b/%h/%h exp=1/240a000a/00000000", instr_valid, instr, bus.addr); end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_9000;
    step();
    redirect  = 1'b0;
    rst_n     = 1'b0;
    bus.ack   = 1'b1;
    bus.rdata = 32'hDEAD_BEEF;
    step();
    total++; if ({bus.req, bus.addr, instr_valid, instr} !== {1'b0, 32'h3000, 1'b0, 32'h0}) begin bad++; $display("FAIL rm_reset got=%b/%h/%b/%h exp=0/3000/0/00000000", bus.req, bus.addr, instr_valid, instr); end
    total++; if ({pc_out, pc_plus4, imm16} !== {32'h3000, 32'h3004, 16'h0}) begin bad++; $display("FAIL rm_reset_pc got=%h/%h/%h exp=3000/3004/0000", pc_out, pc_plus4, imm16); end
    rst_n     = 1'b1;
    stall     = 1'b0;
    bus.rdata = 32'h2008_0005;
    #1;
    total++; if ({bus.req, bus.addr} !== {1'b1, 32'h3000}) begin bad++; $display("FAIL rm_req got=%b/%h exp=1/3000", bus.req, bus.addr); end
    step();
    total++; if ({instr_valid, instr, pc_out} !== {1'b1, 32'h2008_0005, 32'h3000}) begin bad++; $display("FAIL rm_first got=%b/%h/%h exp=1/20080005/3000", instr_valid, instr, pc_out); end
    $display("reset mid-wait: instr=%h pc=%h", instr, pc_out);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect_pending();
    test_redirect_hold();
    test_redirect_zero_wait();
    test_wrap();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
